muldiv: RTL

Multi-cycle multiply/divide unit for the execute stage of the pipelined MIPS CPU, sitting alongside the single-cycle ALU. It receives the same E-stage instruction word and forwarded operands as the ALU. It decodes mult/multu/div/divu/mthi/mtlo/mfhi/mflo, holds the HI/LO architectural registers, and reports a busy status so the hazard unit can stall dependent instructions in D.

---
 rtl/muldiv.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv.sv
// muldiv: multiply/divide unit for the MIPS execute stage. It holds the architectural HI/LO registers.
// Each result is computed at issue into shadow registers and committed to HI/LO after a fixed busy window.
module muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_e,
    input  logic [31:0] numa,
    input  logic [31:0] numb,
    output logic        md_start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MTHI,
        OP_MTLO,
        OP_MFHI,
        OP_MFLO
    } md_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic md_op_e decode_op(input logic [31:0] ir);
        md_op_e op_v;
        op_v = OP_NONE;
        if (ir[31:26] == 6'b000000) begin
            case (ir[5:0])
                6'b011000: op_v = OP_MULT;
                6'b011001: op_v = OP_MULTU;
                6'b011010: op_v = OP_DIV;
                6'b011011: op_v = OP_DIVU;
                6'b010001: op_v = OP_MTHI;
                6'b010011: op_v = OP_MTLO;
                6'b010000: op_v = OP_MFHI;
                6'b010010: op_v = OP_MFLO;
                default:   op_v = OP_NONE;
            endcase
        end else begin
            op_v = OP_NONE;
        end
        return op_v;
    endfunction

    // Low 64 bits of the product of the extended operands equal the signed or unsigned 64-bit product.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        bx = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ax * bx;
    endfunction

    // Divide on magnitudes and restore signs, so 0x80000000 / -1 wraps rather than trapping.
    // The returned value is {remainder, quotient}.
    function automatic logic [63:0] divmod(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        q = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        r = neg_a ? (32'd0 - r_mag) : r_mag;
        return {r, q};
    endfunction

    md_op_e             op_s;
    logic               is_md_s;
    logic               div_zero_s;
    logic [31:0]        res_hi_s;
    logic [31:0]        res_lo_s;
    logic [CNT_W-1:0]   load_cnt_s;

    md_state_e          state_r;
    logic [CNT_W-1:0]   count_r;
    logic               busy_r;
    logic               dz_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic [31:0]        rhi_r;
    logic [31:0]        rlo_r;

    assign op_s       = decode_op(ir_e);
    assign is_md_s    = (op_s == OP_MULT) || (op_s == OP_MULTU) ||
                        (op_s == OP_DIV)  || (op_s == OP_DIVU);
    assign div_zero_s = ((op_s == OP_DIV) || (op_s == OP_DIVU)) && (numb == 32'd0);

    assign md_start = is_md_s & ~busy_r;
    assign busy     = busy_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

    // Full result and busy length for the operation currently in ir_e.
    always_comb begin
        res_hi_s   = 32'd0;
        res_lo_s   = 32'd0;
        load_cnt_s = {CNT_W{1'b0}};
        case (op_s)
            OP_MULT, OP_MULTU: begin
                {res_hi_s, res_lo_s} = mul64(numa, numb, op_s == OP_MULT);
                load_cnt_s           = CNT_W'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                {res_hi_s, res_lo_s} = divmod(numa, numb, op_s == OP_DIV);
                load_cnt_s           = CNT_W'(DIV_CYCLES);
            end
            default: begin
                res_hi_s   = 32'd0;
                res_lo_s   = 32'd0;
                load_cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Move-from read port; reads the committed HI/LO even while an operation is running.
    always_comb begin
        mdout = 32'd0;
        case (op_s)
            OP_MFHI: mdout = hi_r;
            OP_MFLO: mdout = lo_r;
            default: mdout = 32'd0;
        endcase
    end

    // Issue/run/commit state machine owning HI/LO and the shadow result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            dz_r    <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            rhi_r   <= 32'd0;
            rlo_r   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (md_start) begin
                        rhi_r   <= res_hi_s;
                        rlo_r   <= res_lo_s;
                        dz_r    <= div_zero_s;
                        count_r <= load_cnt_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else if (op_s == OP_MTHI) begin
                        hi_r <= numa;
                    end else if (op_s == OP_MTLO) begin
                        lo_r <= numa;
                    end
                end
                ST_RUN: begin
                    // Moves arriving while busy are dropped; only the countdown advances.
                    if (count_r <= CNT_W'(1)) begin
                        if (!dz_r) begin
                            hi_r <= rhi_r;
                            lo_r <= rlo_r;
                        end
                        count_r <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                default: begin
                    count_r <= {CNT_W{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
